dualram_arbiter: RTL and testbench

Two-client arbiter and sequencer for the 16x8 asynchronous dual-port RAM. It accepts read and write requests from client A and client B and grants them round-robin. It drives the RAM's chip-select, write and read ports for exactly one access cycle per transaction, then returns read data and a one-cycle acknowledge to the winning client. It also clears the RAM once after every reset.

---
 rtl/dualram_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_dualram_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dualram_arbiter.sv
// dualram_arbiter
//   Round-robin arbiter and access sequencer placed in front of a 16x8
//   asynchronous dual-port RAM. Two clients (A, B) issue single read or
//   write transactions. Each transaction occupies the RAM for exactly one
//   ACCESS cycle, followed by a COMPLETE cycle that returns read data and
//   pulses the winner's ack. The RAM is cleared once after every reset.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   a_req/a_wr/a_addr/a_wdata client A request (level, sampled in IDLE)
//   b_req/b_wr/b_addr/b_wdata client B request
//   a_ack/a_rdata             client A completion pulse / read data
//   b_ack/b_rdata             client B completion pulse / read data
//   busy                      high whenever the FSM is not in IDLE
//   ram_*                     RAM control, address and data ports
module dualram_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_wr,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   input  logic                  b_req,
   input  logic                  b_wr,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  a_ack,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  b_ack,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  busy,
   output logic                  ram_cs,
   output logic                  ram_rst,
   output logic                  ram_wr_enb,
   output logic                  ram_rd_enb,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   localparam logic [1:0] CLEAR    = 2'd0;
   localparam logic [1:0] IDLE     = 2'd1;
   localparam logic [1:0] ACCESS   = 2'd2;
   localparam logic [1:0] COMPLETE = 2'd3;

   logic [1:0]            state_q, state_d;
   logic                  prio_q, prio_d;       // 0 = A wins a tie, 1 = B
   logic                  cmd_id_q, cmd_id_d;   // 0 = A, 1 = B
   logic                  cmd_wr_q, cmd_wr_d;
   logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_WIDTH-1:0] cmd_wdata_q, cmd_wdata_d;

   logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic                  busy_q, busy_d;
   logic                  cs_q, cs_d, rrst_q, rrst_d;
   logic                  wen_q, wen_d, ren_q, ren_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   logic                  grant_b;
   logic                  sel_wr;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Winner selection: a lone requester wins, a tie goes to the pointer.
   always_comb begin
      grant_b   = b_req && (!a_req || prio_q);
      sel_wr    = grant_b ? b_wr    : a_wr;
      sel_addr  = grant_b ? b_addr  : a_addr;
      sel_wdata = grant_b ? b_wdata : a_wdata;
   end

   // Outputs are registered, so the values for a state are computed on the
   // transition into it (e.g. ram_cs is set on the IDLE->ACCESS edge).
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      cmd_id_d    = cmd_id_q;
      cmd_wr_d    = cmd_wr_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      a_ack_d     = 1'b0;
      b_ack_d     = 1'b0;
      a_rdata_d   = a_rdata_q;
      b_rdata_d   = b_rdata_q;
      busy_d      = 1'b1;
      cs_d        = 1'b0;
      rrst_d      = 1'b0;
      wen_d       = 1'b0;
      ren_d       = 1'b0;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      wdata_d     = wdata_q;
      case (state_q)
         CLEAR: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         IDLE: begin
            busy_d = 1'b0;
            if (a_req || b_req) begin
               cmd_id_d    = grant_b;
               cmd_wr_d    = sel_wr;
               cmd_addr_d  = sel_addr;
               cmd_wdata_d = sel_wdata;
               state_d     = ACCESS;
               busy_d      = 1'b1;
               cs_d        = 1'b1;
               if (sel_wr) begin
                  wen_d   = 1'b1;
                  waddr_d = sel_addr;
                  wdata_d = sel_wdata;
               end else begin
                  ren_d   = 1'b1;
                  raddr_d = sel_addr;
               end
            end
         end
         ACCESS: begin
            // RAM is asynchronous: read data is valid at the end of ACCESS.
            state_d = COMPLETE;
            prio_d  = ~cmd_id_q;
            if (cmd_id_q) begin
               b_ack_d = 1'b1;
               if (!cmd_wr_q) b_rdata_d = ram_rd_data;
            end else begin
               a_ack_d = 1'b1;
               if (!cmd_wr_q) a_rdata_d = ram_rd_data;
            end
         end
         default: begin // COMPLETE
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= CLEAR;
         prio_q      <= 1'b0;
         cmd_id_q    <= 1'b0;
         cmd_wr_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         a_ack_q     <= 1'b0;
         b_ack_q     <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
         busy_q      <= 1'b1;
         cs_q        <= 1'b0;
         rrst_q      <= 1'b1;
         wen_q       <= 1'b0;
         ren_q       <= 1'b0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         cmd_id_q    <= cmd_id_d;
         cmd_wr_q    <= cmd_wr_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         a_ack_q     <= a_ack_d;
         b_ack_q     <= b_ack_d;
         a_rdata_q   <= a_rdata_d;
         b_rdata_q   <= b_rdata_d;
         busy_q      <= busy_d;
         cs_q        <= cs_d;
         rrst_q      <= rrst_d;
         wen_q       <= wen_d;
         ren_q       <= ren_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         wdata_q     <= wdata_d;
      end
   end

   assign a_ack       = a_ack_q;
   assign b_ack       = b_ack_q;
   assign a_rdata     = a_rdata_q;
   assign b_rdata     = b_rdata_q;
   assign busy        = busy_q;
   assign ram_cs      = cs_q;
   assign ram_rst     = rrst_q;
   assign ram_wr_enb  = wen_q;
   assign ram_rd_enb  = ren_q;
   assign ram_wr_addr = waddr_q;
   assign ram_rd_addr = raddr_q;
   assign ram_wr_data = wdata_q;

endmodule

// File: tb/tb_dualram_arbiter.sv
// Directed bench for dualram_arbiter with a behavioural 16x8 async RAM.
module tb_dualram_arbiter;
   localparam int AW = 4;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_req, a_wr, b_req, b_wr;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_ack, b_ack, busy;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          ram_cs, ram_rst, ram_wr_enb, ram_rd_enb;
   logic [AW-1:0] ram_wr_addr, ram_rd_addr;
   logic [DW-1:0] ram_wr_data, ram_rd_data;

   always #5 clk = ~clk;

   dualram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
      .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata), .b_ack(b_ack), .b_rdata(b_rdata),
      .busy(busy), .ram_cs(ram_cs), .ram_rst(ram_rst),
      .ram_wr_enb(ram_wr_enb), .ram_rd_enb(ram_rd_enb),
      .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
      .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
   );

   // RAM model: garbage on the first edge so a missing clear shows up,
   // synchronous clear while ram_rst, write on cs & wr_enb, async read.
   logic [DW-1:0] mem [16];
   logic          seeded = 1'b0;
   always @(posedge clk) begin
      if (!seeded) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
         seeded <= 1'b1;
      end else if (ram_rst) begin
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else if (ram_cs && ram_wr_enb) begin
         mem[ram_wr_addr] <= ram_wr_data;
      end
   end
   assign ram_rd_data = mem[ram_rd_addr];

   int            n_chk = 0;
   int            n_fail = 0;
   logic [DW-1:0] exp_a = '0;
   logic [DW-1:0] exp_b = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k = 0;
      while (busy !== 1'b0 && k < 20) begin
         tick();
         k++;
      end
      if (k == 20) chk("idle_timeout", {31'd0, busy}, 32'd0);
   endtask

   // One isolated transaction: ACCESS and COMPLETE cycles are both checked.
   task automatic txn(input bit cl, input bit wr, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] exp, input string tag);
      wait_idle();
      if (!cl) begin a_req = 1; a_wr = wr; a_addr = addr; a_wdata = wd; end
      else     begin b_req = 1; b_wr = wr; b_addr = addr; b_wdata = wd; end
      tick();
      a_req = 0; b_req = 0;
      chk({tag, "_acc_cs"},  ram_cs, 1);
      chk({tag, "_acc_busy"}, busy, 1);
      chk({tag, "_acc_wen"}, ram_wr_enb, wr);
      chk({tag, "_acc_ren"}, ram_rd_enb, !wr);
      if (wr) begin
         chk({tag, "_acc_waddr"}, ram_wr_addr, addr);
         chk({tag, "_acc_wdata"}, ram_wr_data, wd);
      end else begin
         chk({tag, "_acc_raddr"}, ram_rd_addr, addr);
      end
      chk({tag, "_acc_acks"}, {a_ack, b_ack}, 0);
      tick();
      if (!wr) begin
         if (cl) exp_b = exp; else exp_a = exp;
      end
      chk({tag, "_cmp_ctl"}, {ram_cs, ram_wr_enb, ram_rd_enb}, 0);
      chk({tag, "_cmp_acks"}, {a_ack, b_ack}, {!cl, cl});
      chk({tag, "_cmp_a_rdata"}, a_rdata, exp_a);
      chk({tag, "_cmp_b_rdata"}, b_rdata, exp_b);
      tick();
      chk({tag, "_post"}, {a_ack, b_ack, busy}, 0);
   endtask

   typedef struct {
      bit            cl;    // 0 = A, 1 = B
      bit            wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] exp;   // expected read data (reads only)
   } vec_t;

   vec_t tab [9];
   int   ord [4];
   int   at  [4];

   initial begin
      tab[0] = '{0, 0, 4'd5,  8'h00, 8'h00}; // cleared RAM reads zero
      tab[1] = '{0, 1, 4'd3,  8'hA5, 8'h00};
      tab[2] = '{1, 0, 4'd3,  8'h00, 8'hA5};
      tab[3] = '{0, 1, 4'd15, 8'hFF, 8'h00};
      tab[4] = '{0, 1, 4'd0,  8'h01, 8'h00};
      tab[5] = '{1, 0, 4'd15, 8'h00, 8'hFF};
      tab[6] = '{0, 0, 4'd0,  8'h00, 8'h01}; // no alias from addr 15
      tab[7] = '{1, 1, 4'd7,  8'h3C, 8'h00};
      tab[8] = '{1, 1, 4'd8,  8'h99, 8'h00};

      rst = 1; a_req = 0; b_req = 0; a_wr = 0; b_wr = 0;
      a_addr = 0; b_addr = 0; a_wdata = 0; b_wdata = 0;

      // Reset: two cycles high, then the CLEAR cycle.
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_ram_rst", ram_rst, 1);
         chk("rst_busy", busy, 1);
         chk("rst_outs", {a_ack, b_ack, ram_cs, ram_wr_enb, ram_rd_enb}, 0);
         chk("rst_rdata", {a_rdata, b_rdata}, 0);
      end
      rst = 0;
      chk("clear_ram_rst", ram_rst, 1);
      tick();
      chk("idle_ram_rst", ram_rst, 0);
      chk("idle_busy", busy, 0);
      chk("idle_acks", {a_ack, b_ack}, 0);
      chk("idle_rdata", {a_rdata, b_rdata}, 0);

      for (int i = 0; i < 9; i++)
         txn(tab[i].cl, tab[i].wr, tab[i].addr, tab[i].wdata, tab[i].exp, $sformatf("vec%0d", i));

      // Contention: both hold req for two grants each.
      begin
         int nack = 0, acnt = 0, bcnt = 0, cs_cnt = 0;
         for (int i = 0; i < 4; i++) begin ord[i] = 9; at[i] = 0; end
         wait_idle();
         a_req = 1; a_wr = 1; a_addr = 4'd1; a_wdata = 8'h11;
         b_req = 1; b_wr = 1; b_addr = 4'd2; b_wdata = 8'h22;
         for (int cyc = 0; cyc < 40 && nack < 4; cyc++) begin
            tick();
            if (ram_cs) cs_cnt++;
            if (a_ack && b_ack) chk("cont_dual_ack", 1, 0);
            if (a_ack && nack < 4) begin
               ord[nack] = 0; at[nack] = cyc; nack++; acnt++;
               if (acnt == 2) a_req = 0;
            end
            if (b_ack && nack < 4) begin
               ord[nack] = 1; at[nack] = cyc; nack++; bcnt++;
               if (bcnt == 2) b_req = 0;
            end
         end
         a_req = 0; b_req = 0;
         chk("cont_ack_count", nack, 4);
         for (int i = 0; i < 3; i++) begin
            tick();
            if (ram_cs) cs_cnt++;
         end
         chk("cont_order", {ord[0][3:0], ord[1][3:0], ord[2][3:0], ord[3][3:0]}, 16'h0101);
         for (int i = 1; i < 4; i++)
            chk($sformatf("cont_gap%0d", i), at[i] - at[i-1], 3);
         chk("cont_cs_cycles", cs_cnt, 4);
      end
      txn(0, 0, 4'd1, 8'h00, 8'h11, "cont_rd1");
      txn(1, 0, 4'd2, 8'h00, 8'h22, "cont_rd2");

      // Command stability: address/wr changed during ACCESS.
      wait_idle();
      a_req = 1; a_wr = 0; a_addr = 4'd7;
      tick();
      a_req = 0; a_addr = 4'd8; a_wr = 1; a_wdata = 8'h55;
      chk("stab_raddr", ram_rd_addr, 7);
      chk("stab_ren", {ram_rd_enb, ram_wr_enb}, 2'b10);
      tick();
      exp_a = 8'h3C;
      chk("stab_ack", a_ack, 1);
      chk("stab_rdata", a_rdata, 8'h3C);
      tick();
      txn(1, 0, 4'd8, 8'h00, 8'h99, "stab_addr8");

      // Reset during the ACCESS cycle of a B read.
      wait_idle();
      b_req = 1; b_wr = 0; b_addr = 4'd3;
      tick();
      b_req = 0;
      chk("mrst_cs", ram_cs, 1);
      rst = 1;
      tick();
      rst = 0;
      exp_a = 0; exp_b = 0;
      chk("mrst_no_ack", {a_ack, b_ack}, 0);
      chk("mrst_clear", {ram_rst, busy}, 2'b11);
      chk("mrst_rdata", {a_rdata, b_rdata}, 0);
      tick();
      chk("mrst_idle", {ram_rst, busy, b_ack}, 0);
      txn(1, 0, 4'd3,  8'h00, 8'h00, "mrst_rd3");
      txn(0, 0, 4'd15, 8'h00, 8'h00, "mrst_rd15");
      txn(0, 0, 4'd7,  8'h00, 8'h00, "mrst_rd7");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
